// File: rtl/maxpool_window_ctrl.sv
// Window sequencer for 2x2 stride-2 max pooling over a raster stream of 1-bit pixels.
// Even rows are parked in a one-row line buffer; odd rows pair with it to emit windows.
module maxpool_window_ctrl #(
    parameter  int IMG_W = 24,
    parameter  int IMG_H = 24,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          valid_in,
    input  logic          pixel_in,
    output logic          pixel_0,
    output logic          pixel_1,
    output logic          pixel_2,
    output logic          pixel_3,
    output logic          valid_out_buf,
    output logic [CW-1:0] out_col,
    output logic [RW-1:0] out_row,
    output logic          frame_done
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        POOL = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    col_r, col_s;
    logic [RW-1:0]    row_r, row_s;
    logic [IMG_W-1:0] line_buf_r, line_buf_s;
    logic             prev_pix_r, prev_pix_s;
    logic             col_wrap_s, row_wrap_s;

    logic             pixel_0_s, pixel_1_s, pixel_2_s, pixel_3_s;
    logic             valid_out_s, frame_done_s;
    logic [CW-1:0]    out_col_s;
    logic [RW-1:0]    out_row_s;

    assign col_wrap_s = (col_r == CW'(IMG_W - 1));
    assign row_wrap_s = (row_r == RW'(IMG_H - 1));

    // Next-state, counter advance and window assembly for the accepted pixel
    always_comb begin
        state_s      = state_r;
        col_s        = col_r;
        row_s        = row_r;
        line_buf_s   = line_buf_r;
        prev_pix_s   = prev_pix_r;
        pixel_0_s    = 1'b0;
        pixel_1_s    = 1'b0;
        pixel_2_s    = 1'b0;
        pixel_3_s    = 1'b0;
        valid_out_s  = 1'b0;
        out_col_s    = {CW{1'b0}};
        out_row_s    = {RW{1'b0}};
        frame_done_s = 1'b0;

        if (clear) begin
            state_s    = FILL;
            col_s      = {CW{1'b0}};
            row_s      = {RW{1'b0}};
            prev_pix_s = 1'b0;
        end else if (valid_in) begin
            case (state_r)
                FILL: begin
                    line_buf_s[col_r] = pixel_in;
                end
                POOL: begin
                    prev_pix_s = pixel_in;
                    if (col_r[0]) begin
                        // Trailing odd column never reaches here with col[0]==1 unpaired
                        pixel_0_s   = line_buf_r[col_r - CW'(1)];
                        pixel_1_s   = line_buf_r[col_r];
                        pixel_2_s   = prev_pix_r;
                        pixel_3_s   = pixel_in;
                        valid_out_s = 1'b1;
                        out_col_s   = col_r >> 1;
                        out_row_s   = row_r >> 1;
                    end else begin
                        valid_out_s = 1'b0;
                    end
                end
                default: begin
                    state_s = FILL;
                end
            endcase

            frame_done_s = col_wrap_s && row_wrap_s;

            if (col_wrap_s) begin
                col_s = {CW{1'b0}};
                if (row_wrap_s) begin
                    row_s = {RW{1'b0}};
                end else begin
                    row_s = row_r + RW'(1);
                end
                // Odd trailing row wraps to row 0, so parity of the new row decides
                if (row_s[0]) begin
                    state_s = POOL;
                end else begin
                    state_s = FILL;
                end
            end else begin
                col_s = col_r + CW'(1);
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, line buffer and registered window outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= FILL;
            col_r         <= {CW{1'b0}};
            row_r         <= {RW{1'b0}};
            line_buf_r    <= {IMG_W{1'b0}};
            prev_pix_r    <= 1'b0;
            pixel_0       <= 1'b0;
            pixel_1       <= 1'b0;
            pixel_2       <= 1'b0;
            pixel_3       <= 1'b0;
            valid_out_buf <= 1'b0;
            out_col       <= {CW{1'b0}};
            out_row       <= {RW{1'b0}};
            frame_done    <= 1'b0;
        end else begin
            state_r       <= state_s;
            col_r         <= col_s;
            row_r         <= row_s;
            line_buf_r    <= line_buf_s;
            prev_pix_r    <= prev_pix_s;
            pixel_0       <= pixel_0_s;
            pixel_1       <= pixel_1_s;
            pixel_2       <= pixel_2_s;
            pixel_3       <= pixel_3_s;
            valid_out_buf <= valid_out_s;
            out_col       <= out_col_s;
            out_row       <= out_row_s;
            frame_done    <= frame_done_s;
        end
    end

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Bench for maxpool_window_ctrl: a 4x4 and a 5x5 instance share one stimulus stream and
// are checked every cycle against an image-array model, plus directed literal expectations.
module tb_maxpool_window_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic valid_in = 1'b0;
    logic pixel_in = 1'b0;

    logic a0, a1, a2, a3, v4, fd4;
    logic [1:0] oc4, or4;
    logic b0, b1, b2, b3, v5, fd5;
    logic [2:0] oc5, or5;

    always #5 clk = ~clk;

    maxpool_window_ctrl #(.IMG_W(4), .IMG_H(4)) u4 (
        .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in), .pixel_in(pixel_in),
        .pixel_0(a0), .pixel_1(a1), .pixel_2(a2), .pixel_3(a3),
        .valid_out_buf(v4), .out_col(oc4), .out_row(or4), .frame_done(fd4)
    );

    maxpool_window_ctrl #(.IMG_W(5), .IMG_H(5)) u5 (
        .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in), .pixel_in(pixel_in),
        .pixel_0(b0), .pixel_1(b1), .pixel_2(b2), .pixel_3(b3),
        .valid_out_buf(v5), .out_col(oc5), .out_row(or5), .frame_done(fd5)
    );

    // Packed view: [21]=frame_done [20]=valid [19:16]=p0..p3 [15:8]=out_row [7:0]=out_col
    logic [31:0] act4, act5;
    assign act4 = {10'd0, fd4, v4, a0, a1, a2, a3, 6'd0, or4, 6'd0, oc4};
    assign act5 = {10'd0, fd5, v5, b0, b1, b2, b3, 5'd0, or5, 5'd0, oc5};

    int tests = 0;
    int fails = 0;

    bit          img [0:1][0:4][0:4];
    int          kpos [0:1];
    logic [31:0] expv [0:1];

    int pidx = 0;
    int last_idx = 0;
    int log_idx[$];
    logic [3:0] log_bits[$];
    int log_pos[$];
    bit log_fd[$];
    int fd4_cnt = 0;
    int s5_cnt = 0;
    int fd5_cnt = 0;
    int fd5_idx = -1;
    int bad5 = 0;

    localparam logic [15:0] PAT = 16'b1000_0000_0000_0001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: pixel k of a W x H frame lives at (k/W, k%W); windows close on odd/odd
    task automatic mstep(input int id, input int w, input int h,
                         input bit rs, input bit c, input bit v, input bit p);
        int r;
        int col;
        expv[id] = 32'd0;
        if (rs || c) begin
            kpos[id] = 0;
        end else if (v) begin
            r = kpos[id] / w;
            col = kpos[id] % w;
            img[id][r][col] = p;
            expv[id][21] = (kpos[id] == w * h - 1);
            if ((r % 2 == 1) && (col % 2 == 1)) begin
                expv[id][20] = 1'b1;
                expv[id][19] = img[id][r-1][col-1];
                expv[id][18] = img[id][r-1][col];
                expv[id][17] = img[id][r][col-1];
                expv[id][16] = p;
                expv[id][15:8] = 8'(r / 2);
                expv[id][7:0] = 8'(col / 2);
            end
            kpos[id] = (kpos[id] + 1) % (w * h);
        end
    endtask

    task automatic cycle(input bit c, input bit v, input bit p);
        clear = c;
        valid_in = v;
        pixel_in = p;
        @(posedge clk);
        mstep(0, 4, 4, rst, c, v, p);
        mstep(1, 5, 5, rst, c, v, p);
        if (rst || c) begin
            pidx = 0;
        end else if (v) begin
            last_idx = pidx;
            pidx++;
        end
        #1;
        chk("win4", act4, expv[0]);
        chk("win5", act5, expv[1]);
        if (v4) begin
            log_idx.push_back(last_idx);
            log_bits.push_back({a0, a1, a2, a3});
            log_pos.push_back(int'(or4) * 2 + int'(oc4));
            log_fd.push_back(fd4);
        end
        if (fd4) fd4_cnt++;
        if (v5) begin
            s5_cnt++;
            if ({b0, b1, b2, b3} != 4'b1111) bad5++;
        end
        if (fd5) begin
            fd5_cnt++;
            fd5_idx = last_idx;
        end
    endtask

    task automatic clear_logs();
        log_idx.delete();
        log_bits.delete();
        log_pos.delete();
        log_fd.delete();
        fd4_cnt = 0;
    endtask

    task automatic feed4(input logic [15:0] pat, input bit gaps);
        logic [15:0] pv;
        pv = pat;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, pv[15-i]);
            if (gaps) cycle(1'b0, 1'b0, 1'($urandom % 2));
        end
    endtask

    task automatic check_log4(input string tag);
        int eidx [0:3];
        logic [3:0] ebits [0:3];
        eidx = '{5, 7, 13, 15};
        ebits = '{4'b1000, 4'b0000, 4'b0000, 4'b0001};
        chk({tag, "_count"}, 32'(log_idx.size()), 32'd4);
        if (log_idx.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk({tag, "_idx"}, 32'(log_idx[i]), 32'(eidx[i]));
                chk({tag, "_bits"}, 32'(log_bits[i]), 32'(ebits[i]));
                chk({tag, "_pos"}, 32'(log_pos[i]), 32'(i));
            end
            chk({tag, "_fd_with_last"}, 32'(log_fd[3]), 32'd1);
        end
        chk({tag, "_fd_count"}, 32'(fd4_cnt), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            kpos[i] = 0;
            expv[i] = 32'd0;
        end

        // Reset and idle
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) begin
            cycle(1'b0, 1'b0, 1'b0);
            chk("rst_idle4", act4, 32'd0);
        end

        // Continuous 4x4 pattern
        cycle(1'b1, 1'b0, 1'b0);
        clear_logs();
        feed4(PAT, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check_log4("cont");

        // Same frame with idle gaps between pixels
        cycle(1'b1, 1'b0, 1'b0);
        clear_logs();
        feed4(PAT, 1'b1);
        check_log4("gap");

        // 5x5 all ones: floor behaviour drops trailing row/column
        cycle(1'b1, 1'b0, 1'b0);
        s5_cnt = 0;
        fd5_cnt = 0;
        bad5 = 0;
        repeat (25) cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("ones5_strobes", 32'(s5_cnt), 32'd4);
        chk("ones5_bits", 32'(bad5), 32'd0);
        chk("ones5_fd_count", 32'(fd5_cnt), 32'd1);
        chk("ones5_fd_idx", 32'(fd5_idx), 32'd24);

        // Clear collides with the pixel at (1,1)
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'($urandom % 2));
        clear_logs();
        cycle(1'b1, 1'b1, 1'b1);
        chk("clr_drop", 32'(v4), 32'd0);
        feed4(PAT, 1'b0);
        check_log4("after_clr");

        // Two back-to-back frames
        cycle(1'b1, 1'b0, 1'b0);
        clear_logs();
        feed4(PAT, 1'b0);
        feed4(PAT, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("b2b_count", 32'(log_idx.size()), 32'd8);
        if (log_idx.size() == 8) begin
            chk("b2b_restart_pos", 32'(log_pos[4]), 32'd0);
            chk("b2b_restart_idx", 32'(log_idx[4]), 32'd21);
            chk("b2b_last_bits", 32'(log_bits[7]), 32'd1);
        end
        chk("b2b_fd_count", 32'(fd4_cnt), 32'd2);

        // Random traffic with occasional clears
        repeat (1500) cycle(($urandom % 64) == 0, ($urandom % 4) != 0, 1'($urandom % 2));

        // Asynchronous reset mid-cycle
        repeat (7) cycle(1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst4", act4, 32'd0);
        chk("async_rst5", act5, 32'd0);
        repeat (2) cycle(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        repeat (800) cycle(($urandom % 80) == 0, ($urandom % 3) != 0, 1'($urandom % 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/maxpool_window_ctrl.md
# maxpool_window_ctrl

Sequencer that sits between the binary convolution output stream and the 2x2 max-pooling calculation unit. It accepts a raster-order stream of 1-bit pixels and buffers one image row. For every non-overlapping 2x2 window (stride 2) it presents the four pixels and a one-cycle `valid_out_buf` strobe to the pooling unit. It also tracks the pooled-output coordinates and flags the end of each frame.

## Interface

Parameters:
- `IMG_W`, 24: input image width in pixels; must be ≥ 2.
- `IMG_H`, 24: input image height in pixels; must be ≥ 2.
- `CW`, `$clog2(IMG_W)`: width of the column counter (localparam).
- `RW`, `$clog2(IMG_H)`: width of the row counter (localparam).

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clear` input 1: synchronous frame abort. Returns the block to the row 0 / column 0 position.
- `valid_in` input 1: `pixel_in` is valid this cycle. No backpressure exists.
- `pixel_in` input 1: binary pixel, raster order, row-major.
- `pixel_0` output 1: window top-left (row r-1, col c-1).
- `pixel_1` output 1: window top-right (row r-1, col c).
- `pixel_2` output 1: window bottom-left (row r, col c-1).
- `pixel_3` output 1: window bottom-right (row r, col c).
- `valid_out_buf` output 1: one-cycle strobe marking the window outputs valid.
- `out_col` output CW: pooled column index, (c-1)/2, valid with the strobe.
- `out_row` output RW: pooled row index, (r-1)/2, valid with the strobe.
- `frame_done` output 1: one-cycle pulse after the last pixel of a frame.

## Operation

- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on `valid_in`.
  - `col` wraps to 0 at IMG_W-1 and increments `row`.
  - `row` wraps to 0 at IMG_H-1 and completes the frame.
- States:
  - FILL: the current row index is even. Each accepted pixel is written to `line_buf[col]`, an IMG_W-bit register array. No windows are emitted.
  - POOL: the current row index is odd. Each accepted pixel is held in `prev_pix`.
  - The state is a function of `row[0]`. FILL → POOL when `col` wraps on an even row. POOL → FILL when `col` wraps on an odd row.
- Window emit condition: accepted pixel in POOL with `col[0]==1`. The registered outputs are then:
  - `pixel_0 = line_buf[col-1]`
  - `pixel_1 = line_buf[col]`
  - `pixel_2 = prev_pix`
  - `pixel_3 = pixel_in`
  - `valid_out_buf = 1`, `out_col = col>>1`, `out_row = row>>1`
- No window is emitted for a trailing odd column (IMG_W odd) or a trailing odd row (IMG_H odd). Those pixels are consumed and ignored (floor behaviour).
- `frame_done` pulses when the pixel at (IMG_H-1, IMG_W-1) is accepted. The next frame starts immediately at (0,0).
- `clear`:
  - Zeroes `col`, `row`, `prev_pix` and all outputs.
  - Leaves `line_buf` unchanged; its contents are don't-care and are overwritten before use.
  - Has priority over `valid_in` in the same cycle; that pixel is dropped.
- `valid_out_buf` is low in every cycle that is not an emit cycle. The window pixel outputs, `out_col` and `out_row` return to 0 when no window is emitted.

## Timing

- Reset value of every output is 0. The asynchronous assertion of `rst` clears the counters, `prev_pix` and all outputs immediately; `line_buf` is also cleared to 0.
- Latency: 1 cycle. Outputs update on the edge that accepts bottom-right pixel (r, c) and are valid for exactly one cycle.
- `frame_done` is registered and coincides with the final window strobe. When IMG_W and IMG_H are both even, both are high in the same cycle.
- Gaps in `valid_in`:
  - All state holds during gaps.
  - Windows spanning gaps are assembled correctly.
  - `valid_out_buf` never repeats during gaps.
- Throughput: one pixel per cycle sustained. The strobe rate is at most one every 2 cycles.
- `rst` or `clear` mid-frame: the next accepted pixel is treated as (0,0), and no strobe is emitted until the block reaches row 1, column 1 again.

## Test plan

- Reset: assert `rst` asynchronously mid-cycle → all outputs read 0 immediately and stay 0 for 3 idle cycles after release.
- IMG_W=4, IMG_H=4, continuous stream of the pattern row0=1000, row1=0000, row2=0000, row3=0001:
  - 4 strobes, at pixel cycles 5, 7, 13 and 15.
  - Window bits {p0,p1,p2,p3} are 1000, 0000, 0000 and 0001.
  - `out_row/out_col` are (0,0), (0,1), (1,0) and (1,1).
  - `frame_done` is high with the 4th strobe.
- Same frame with `valid_in` toggling 1,0,1,0 → identical window contents and indices, with each strobe exactly one cycle wide.
- IMG_W=5, IMG_H=5 of all ones → exactly 4 strobes, all windows 1111, and `frame_done` one cycle after the 25th pixel.
- `clear` asserted together with `valid_in` at pixel (1,1), followed by a fresh 4x4 frame → no strobe for the dropped pixel, then 4 correct strobes for the new frame.
- Two back-to-back 4x4 frames with no idle cycle → 8 strobes, `out_row/out_col` restart at (0,0), and `frame_done` pulses twice.
